// File: rtl/servo_pkg.sv
// Shared defaults and the write-clamp rule for the servo pulse generator.
package servo_pkg;

    localparam int unsigned CLK_HZ_DEF    = 16_000_000;
    localparam int unsigned PERIOD_US_DEF = 20_000;
    localparam int unsigned MIN_US_DEF    = 500;
    localparam int unsigned MAX_US_DEF    = 2_500;
    localparam int unsigned WIDTH_DEF     = 16;

    // Zero means "no pulse" and is passed through; anything else is forced into [lo, hi].
    function automatic int unsigned clamp_us(
        input int unsigned req,
        input int unsigned lo,
        input int unsigned hi
    );
        if (req == 0) begin
            return 0;
        end
        if (req < lo) begin
            return lo;
        end
        if (req > hi) begin
            return hi;
        end
        return req;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running prescaler: one-cycle TICK every microsecond of CLK.
module us_tick_gen #(
    parameter int unsigned CLK_HZ = 16_000_000
) (
    input  logic CLK,
    input  logic RESET,
    output logic TICK
);

    localparam int unsigned DIV = CLK_HZ / 1_000_000;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign TICK = (count == CW'(DIV - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count <= '0;
        end else if (TICK) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/servo_pwm.sv
// Frame-synchronous servo pulse generator with double-buffered width updates.
module servo_pwm
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ    = CLK_HZ_DEF,
    parameter int unsigned PERIOD_US = PERIOD_US_DEF,
    parameter int unsigned MIN_US    = MIN_US_DEF,
    parameter int unsigned MAX_US    = MAX_US_DEF,
    parameter int unsigned WIDTH     = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] WR_DATA,
    input  logic             ENABLE,
    output logic             SERVO,
    output logic             FRAME_START,
    output logic [WIDTH-1:0] ACTIVE_WIDTH
);

    localparam int unsigned CNT_W = $clog2(PERIOD_US);

    logic             tick;
    logic             first_frame;
    logic             boundary;
    logic [CNT_W-1:0] us_count;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] wr_clamped;
    logic             en_act;

    us_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .CLK   (CLK),
        .RESET (RESET),
        .TICK  (tick)
    );

    assign wr_clamped = WIDTH'(clamp_us(32'(WR_DATA), MIN_US, MAX_US));

    // The first tick after reset opens a frame without waiting for a full period.
    assign boundary = tick && (first_frame || (us_count == CNT_W'(PERIOD_US - 1)));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            us_count     <= '0;
            first_frame  <= 1'b1;
            pending      <= '0;
            ACTIVE_WIDTH <= '0;
            en_act       <= 1'b0;
            FRAME_START  <= 1'b0;
            SERVO        <= 1'b0;
        end else begin
            FRAME_START <= boundary;

            if (tick) begin
                us_count    <= boundary ? '0 : us_count + CNT_W'(1);
                first_frame <= 1'b0;
            end

            if (WR_EN) begin
                pending <= wr_clamped;
            end

            // A write landing on the boundary itself applies to the frame it opens.
            if (boundary) begin
                ACTIVE_WIDTH <= WR_EN ? wr_clamped : pending;
                en_act       <= ENABLE;
            end

            SERVO <= en_act && (ACTIVE_WIDTH != '0) && (WIDTH'(us_count) < ACTIVE_WIDTH);
        end
    end

endmodule
